tone_sel_ctrl: RTL and testbench
================================

# tone_sel_ctrl

Sequencing controller for the direction-tone frequency mux. Takes four raw direction buttons (up, right, down, left), synchronizes and debounces them, arbitrates when several are pressed, and drives the mux's 3-bit select (`sel[2]` = tone on, `sel[1:0]` = direction). It enforces a minimum tone duration and a silent gap between tones so the PWM output never chatters.

## Interface
- `DEB_CYCLES`, 16: consecutive stable cycles needed to accept a button change (≥1).
- `MIN_ON`, 1000: minimum cycles a granted tone stays selected (≥1).
- `GAP`, 100: silent cycles (`sel`=000) after each tone (≥0; 0 skips GAP state).
- `clk`  in  1  single clock for all logic.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `btn`  in  4  raw buttons, asynchronous to `clk`; [3]=up, [2]=right, [1]=down, [0]=left; 1=pressed.
- `enable`  in  1  synchronous; 0 forces silence.
- `sel`  out  3  registered mux select: 100 up, 101 right, 110 down, 111 left, 000 off.
- `busy`  out  1  registered; 1 in PLAY or GAP.
- `tone_start`  out  1  registered one-cycle pulse, coincident with `sel` leaving 000 for a tone.

## Operation
- Sync: 2-flop synchronizer per `btn` bit.
- Debounce: per bit, counter of width clog2(DEB_CYCLES+1); increments while synced ≠ debounced, clears when equal. Debounced bit toggles when count reaches DEB_CYCLES−1 with mismatch still present; counter then clears.
- Grant index g ∈ {3,2,1,0}; `sel` = {1, 2'(3−g)} in PLAY, 000 otherwise.
- States IDLE, PLAY, GAP:
  - IDLE: `enable`=1 and any debounced bit set → grant per arbitration, load on-timer with MIN_ON−1, go to PLAY, pulse `tone_start`.
  - PLAY: on-timer counts down to 0 and holds there. When timer=0, leave if granted bit released or a preempting request exists (see Configuration). Leaving goes to GAP (GAP timer loaded GAP−1), or to IDLE if GAP=0.
  - GAP: timer counts down; at 0 → IDLE. Re-arbitration happens in IDLE, so a new tone starts ≥1 cycle after GAP ends.
- `enable`=0 in any state: next state IDLE, `sel`=000, `busy`=0, timers cleared, MIN_ON and GAP not honored; arbitration pointer retained.
- Release before MIN_ON elapsed: tone held until timer=0, then exits.
- Timers are clog2(max(MIN_ON,GAP)+1) bits, unsigned, and never wrap.

## Timing
- Reset values: `sel`=000, `busy`=0, `tone_start`=0, state IDLE, debounced bits 0, sync flops 0, RR pointer 0 (left).
- Press-to-tone latency, with `btn` stable from cycle 0 and controller in IDLE:
  - synced at cycle 2;
  - debounced at cycle 2+DEB_CYCLES;
  - `sel`/`tone_start` at cycle 3+DEB_CYCLES.
- Tone length = max(MIN_ON, held time) cycles. GAP is exactly GAP cycles of `sel`=000 with `busy`=1.
- Asserting `rst_n` mid-tone clears all outputs immediately (asynchronously). Deassertion is synchronized externally by the system.

## Configuration
- `TONE_RR_EN` defined: round-robin arbitration.
  - Search starts at the direction after the last grant, cyclic order up→right→down→left→up.
  - In PLAY, with timer=0, any other pending button preempts (time-shares the tone).
- `TONE_RR_EN` undefined: fixed priority up > right > down > left.
  - In PLAY, with timer=0, only a higher-priority pending button preempts.
  - Pointer logic is absent.

## Test plan
- Reset (DEB_CYCLES=4, MIN_ON=20, GAP=5): hold `rst_n`=0 with `btn`=1111 → `sel`=000, `busy`=0, `tone_start`=0 throughout.
- Single press: `btn`=1000 from cycle 0, held 50 cycles → `sel`=100 and `tone_start`=1 at cycle 7. After release, `sel`=000 once debounced, then `busy`=1 for 5 cycles, then 0.
- Glitch: `btn[2]` high for 3 cycles → no debounced change, `sel` stays 000, `tone_start` never pulses.
- Min duration: `btn`=0100 for 6 cycles → `sel`=101 for exactly 20 cycles, then 5 GAP cycles.
- Arbitration, simultaneous `btn`=1001 held 200 cycles:
  - without `TONE_RR_EN`: `sel`=100 continuously;
  - with it: tones alternate 100 (20 cycles), 5-cycle gap, 1 idle cycle, 111, and so on.
- Abort: `enable`→0 at cycle 10 of a tone → `sel`=000 and `busy`=0 on the next edge. Re-enable with the button held → new tone after 1 IDLE cycle.

Source files
------------

// File: rtl/tone_sel_if.sv
// tone_sel_if: button/enable inputs and tone-select outputs of the direction
// tone sequencing controller. The master side drives buttons and enable; the
// slave side (tone_sel_ctrl) returns the mux select, busy flag and start pulse.
interface tone_sel_if;
  logic [3:0] btn;
  logic       enable;
  logic [2:0] sel;
  logic       busy;
  logic       tone_start;

  modport master (output btn, enable, input sel, busy, tone_start);
  modport slave  (input btn, enable, output sel, busy, tone_start);
endinterface

// File: rtl/tone_sel_ctrl.sv
// tone_sel_ctrl: synchronizes and debounces four direction buttons, arbitrates
// among them and drives the tone mux select with a minimum on-time and a
// silent gap after every tone.
// Optional feature macro TONE_RR_EN: round-robin arbitration with time-sharing
// preemption; when undefined, fixed priority up > right > down > left.
module tone_sel_ctrl #(
  parameter int DEB_CYCLES = 16,
  parameter int MIN_ON     = 1000,
  parameter int GAP        = 100
) (
  input logic       clk,
  input logic       rst_n,
  tone_sel_if.slave bus
);

  localparam int DCW  = $clog2(DEB_CYCLES + 1);
  localparam int TMAX = (MIN_ON > GAP) ? MIN_ON : GAP;
  localparam int TW   = $clog2(TMAX + 1);

  localparam logic [DCW-1:0] DEB_LAST = DCW'(DEB_CYCLES - 1);
  localparam logic [TW-1:0]  ON_LD    = TW'(MIN_ON - 1);
  localparam logic [TW-1:0]  GAP_LD   = TW'((GAP > 0) ? (GAP - 1) : 0);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PLAY = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [3:0]     sync_p0;
  logic [3:0]     sync_p1;
  logic [DCW-1:0] deb_cnt [4];
  logic [3:0]     deb;

  logic [1:0]     state;
  logic [1:0]     state_nx;
  logic [TW-1:0]  timer;
  logic [TW-1:0]  timer_nx;
  logic [1:0]     grant;
  logic [1:0]     grant_nx;
  logic           start_nx;
  logic [1:0]     pick;
  logic           preempt;

  // Fixed priority: highest set bit wins (up is bit 3).
  function automatic logic [1:0] prio_pick(input logic [3:0] req);
    if (req[3])      return 2'd3;
    else if (req[2]) return 2'd2;
    else if (req[1]) return 2'd1;
    else             return 2'd0;
  endfunction

`ifdef TONE_RR_EN
  logic [1:0] ptr;

  // Cyclic order up->right->down->left is descending index; the direction
  // right after the last grant gets the highest precedence, the last grant
  // itself the lowest.
  function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] sel_idx;
    sel_idx = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last - 2'(k);
      if (req[idx]) sel_idx = idx;
    end
    return sel_idx;
  endfunction

  // Any pending direction other than the current one shares the tone.
  function automatic logic other_pending(input logic [3:0] req, input logic [1:0] g);
    logic [3:0] mask;
    mask = ~(4'b0001 << g);
    return |(req & mask);
  endfunction

  assign pick    = rr_pick(deb, ptr);
  assign preempt = other_pending(deb, grant);

  // Remember the last granted direction; kept across enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ptr <= 2'd0;
    else if (start_nx) ptr <= grant_nx;
  end
`else
  // Only a strictly higher-priority direction may cut the tone short.
  function automatic logic higher_pending(input logic [3:0] req, input logic [1:0] g);
    logic [3:0] mask;
    mask = 4'b1110 << g;
    return |(req & mask);
  endfunction

  assign pick    = prio_pick(deb);
  assign preempt = higher_pending(deb, grant);
`endif

  // Stage 0/1: two-flop synchronizer for the asynchronous buttons.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.btn;
      sync_p1 <= sync_p0;
    end
  end

  // Debounce: accept a change only after DEB_CYCLES consecutive mismatches.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) deb_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync_p1[i] == deb[i]) begin
          deb_cnt[i] <= '0;
        end else if (deb_cnt[i] == DEB_LAST) begin
          deb[i]     <= sync_p1[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + DCW'(1);
        end
      end
    end
  end

  // Sequencer next state: IDLE arbitrates, PLAY holds for the minimum time,
  // GAP enforces silence; enable low aborts everything back to IDLE.
  always_comb begin
    state_nx = state;
    timer_nx = timer;
    grant_nx = grant;
    start_nx = 1'b0;
    if (!bus.enable) begin
      state_nx = S_IDLE;
      timer_nx = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (|deb) begin
            state_nx = S_PLAY;
            grant_nx = pick;
            timer_nx = ON_LD;
            start_nx = 1'b1;
          end
        end
        S_PLAY: begin
          if (timer != '0) begin
            timer_nx = timer - TW'(1);
          end else if (!deb[grant] || preempt) begin
            if (GAP > 0) begin
              state_nx = S_GAP;
              timer_nx = GAP_LD;
            end else begin
              state_nx = S_IDLE;
            end
          end
        end
        S_GAP: begin
          if (timer != '0) timer_nx = timer - TW'(1);
          else             state_nx = S_IDLE;
        end
        default: begin
          state_nx = S_IDLE;
          timer_nx = '0;
        end
      endcase
    end
  end

  // Stage 2: sequencer state plus registered select, busy and start pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      timer          <= '0;
      grant          <= 2'd0;
      bus.sel        <= 3'b000;
      bus.busy       <= 1'b0;
      bus.tone_start <= 1'b0;
    end else begin
      state          <= state_nx;
      timer          <= timer_nx;
      grant          <= grant_nx;
      bus.sel        <= (state_nx == S_PLAY) ? {1'b1, 2'd3 - grant_nx} : 3'b000;
      bus.busy       <= (state_nx != S_IDLE);
      bus.tone_start <= start_nx;
    end
  end

endmodule

// File: tb/tb_tone_sel_ctrl.sv
// tb_tone_sel_ctrl: table-driven directed scenarios, hand-written abort and
// asynchronous-reset sequences, and randomized button traffic compared every
// cycle against a behavioural model of the tone sequencer.
module tb_tone_sel_ctrl;

  localparam int DEB = 4;
  localparam int MON = 20;
  localparam int GP  = 5;

  localparam int M_IDLE = 0;
  localparam int M_PLAY = 1;
  localparam int M_GAP  = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tone_sel_if bus();

  tone_sel_ctrl #(.DEB_CYCLES(DEB), .MIN_ON(MON), .GAP(GP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, $signed(act), $signed(exp), $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  logic [3:0] m_s1, m_s2, m_deb;
  int         m_run [4];
  int         m_mode, m_age, m_g, m_last;
  logic       m_start;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_deb = '0;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    m_mode = M_IDLE; m_age = 0; m_g = 0; m_last = 0; m_start = 1'b0;
  endtask

  function automatic int arbitrate(input logic [3:0] req);
`ifdef TONE_RR_EN
    int pos;
    int d;
    pos = 3 - m_last;                  // position in order up,right,down,left
    for (int step = 1; step <= 4; step++) begin
      d = 3 - ((pos + step) % 4);
      if (req[d]) return d;
    end
    return m_last;
`else
    for (int d = 3; d >= 0; d--) if (req[d]) return d;
    return 0;
`endif
  endfunction

  function automatic bit preempts(input logic [3:0] req);
`ifdef TONE_RR_EN
    for (int j = 0; j < 4; j++) if (j != m_g && req[j]) return 1'b1;
`else
    for (int j = m_g + 1; j < 4; j++) if (req[j]) return 1'b1;
`endif
    return 1'b0;
  endfunction

  task automatic model_step();
    logic [3:0] req;
    req     = m_deb;
    m_start = 1'b0;
    if (!bus.enable) begin
      m_mode = M_IDLE;
      m_age  = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (req != 0) begin
          m_g = arbitrate(req); m_last = m_g;
          m_mode = M_PLAY; m_age = 1; m_start = 1'b1;
        end
        M_PLAY: begin
          if (m_age < MON) m_age++;
          else if (!req[m_g] || preempts(req)) begin
            if (GP == 0) m_mode = M_IDLE;
            else begin m_mode = M_GAP; m_age = 1; end
          end
        end
        default: begin
          if (m_age < GP) m_age++;
          else m_mode = M_IDLE;
        end
      endcase
    end
    for (int i = 0; i < 4; i++) begin
      if (m_s2[i] != m_deb[i]) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin m_deb[i] = m_s2[i]; m_run[i] = 0; end
      end else begin
        m_run[i] = 0;
      end
    end
    m_s2 = m_s1;
    m_s1 = bus.btn;
  endtask

  task automatic tick();
    logic [2:0] esel;
    @(posedge clk);
    if (!rst_n) model_reset();
    else        model_step();
    #1;
    esel = (m_mode == M_PLAY) ? {1'b1, 2'(3 - m_g)} : 3'b000;
    check("model_sel",   bus.sel, esel);
    check("model_busy",  bus.busy, (m_mode != M_IDLE));
    check("model_start", bus.tone_start, m_start);
  endtask

  // Drive btn=a for 'hold' cycles then b, over 'total' cycles, and summarise.
  task automatic observe(input logic [3:0] a, input int hold, input logic [3:0] b, input int total,
                         output int first_on, output int on_cnt, output int gap_cnt,
                         output int starts, output logic [2:0] sel1, output logic [2:0] sel2);
    first_on = -1; on_cnt = 0; gap_cnt = 0; starts = 0; sel1 = '0; sel2 = '0;
    for (int t = 1; t <= total; t++) begin
      bus.btn = (t <= hold) ? a : b;
      tick();
      if (bus.tone_start) begin
        starts++;
        if (starts == 1) begin sel1 = bus.sel; first_on = t; end
        else if (starts == 2) sel2 = bus.sel;
      end
      if (bus.sel != 3'b000) on_cnt++;
      else if (bus.busy)     gap_cnt++;
    end
  endtask

  typedef struct {
    logic [3:0] a;
    int         hold;
    logic [3:0] b;
    int         total;
    int         first_on;
    int         on_cnt;
    int         gap_cnt;
    int         starts;
    logic [2:0] sel1;
    logic [2:0] sel2;
  } vec_t;

  vec_t vecs [4];

  initial begin
    int         fo, oc, gc, st;
    logic [2:0] s1, s2;
    bit         found;
    logic [3:0] rb;
    int         rh;

    // Arbitration first so the round-robin pointer is still at its reset value.
`ifdef TONE_RR_EN
    vecs[0] = '{4'b1001, 200, 4'b0000, 240, 7, 160, 40, 8, 3'b100, 3'b111};
`else
    vecs[0] = '{4'b1001, 200, 4'b0000, 240, 7, 200, 5, 1, 3'b100, 3'b000};
`endif
    vecs[1] = '{4'b1000, 50, 4'b0000, 80, 7, 50, 5, 1, 3'b100, 3'b000};
    vecs[2] = '{4'b0100, 3,  4'b0000, 30, -1, 0, 0, 0, 3'b000, 3'b000};
    vecs[3] = '{4'b0100, 6,  4'b0000, 60, 7, 20, 5, 1, 3'b101, 3'b000};

    model_reset();
    bus.btn    = 4'b1111;
    bus.enable = 1'b1;

    // Reset held with all buttons pressed: outputs stay quiet.
    for (int i = 0; i < 10; i++) begin
      tick();
      check("rst_sel", bus.sel, 3'b000);
      check("rst_busy", bus.busy, 1'b0);
      check("rst_start", bus.tone_start, 1'b0);
    end
    bus.btn = 4'b0000;
    rst_n   = 1'b1;
    repeat (5) tick();

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      observe(vecs[i].a, vecs[i].hold, vecs[i].b, vecs[i].total, fo, oc, gc, st, s1, s2);
      check($sformatf("vec%0d_first_on", i), fo, vecs[i].first_on);
      check($sformatf("vec%0d_on_cycles", i), oc, vecs[i].on_cnt);
      check($sformatf("vec%0d_gap_cycles", i), gc, vecs[i].gap_cnt);
      check($sformatf("vec%0d_starts", i), st, vecs[i].starts);
      check($sformatf("vec%0d_sel1", i), s1, vecs[i].sel1);
      check($sformatf("vec%0d_sel2", i), s2, vecs[i].sel2);
    end

    // Abort by enable at tone cycle 10, then re-enable with button held.
    bus.btn = 4'b0010;
    found   = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (bus.tone_start) found = 1'b1;
    end
    check("abort_tone_seen", found, 1'b1);
    repeat (9) tick();
    check("abort_pre_sel", bus.sel, 3'b110);
    bus.enable = 1'b0;
    tick();
    check("abort_sel", bus.sel, 3'b000);
    check("abort_busy", bus.busy, 1'b0);
    repeat (3) tick();
    check("abort_hold_sel", bus.sel, 3'b000);
    bus.enable = 1'b1;
    tick();
    check("reen_sel", bus.sel, 3'b110);
    check("reen_start", bus.tone_start, 1'b1);
    bus.btn = 4'b0000;
    repeat (60) tick();
    check("abort_settle_busy", bus.busy, 1'b0);

    // Asynchronous reset in the middle of a tone.
    bus.btn = 4'b1000;
    found   = 1'b0;
    for (int t = 0; t < 40 && !found; t++) begin
      tick();
      if (bus.tone_start) found = 1'b1;
    end
    check("arst_tone_seen", found, 1'b1);
    repeat (3) tick();
    check("arst_pre_sel", bus.sel, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", bus.sel, 3'b000);
    check("arst_busy", bus.busy, 1'b0);
    check("arst_start", bus.tone_start, 1'b0);
    bus.btn = 4'b0000;
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (5) tick();

    // Randomized traffic against the model.
    for (int k = 0; k < 70; k++) begin
      rb = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) rb = 4'b0000;
      rh = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 5) : $urandom_range(6, 70);
      bus.enable = ($urandom_range(0, 9) != 0);
      bus.btn    = rb;
      for (int t = 0; t < rh; t++) tick();
    end
    bus.enable = 1'b1;
    bus.btn    = 4'b0000;
    repeat (60) tick();
    check("final_idle_busy", bus.busy, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
